// File: rtl/seg_scan_decoder_if.sv
// Scan-sample bus between a display scanner (master) and the decoder (slave).
//
// Transfer semantics: scan_en is a strobe with no back-pressure. Every cycle
// with scan_en=1 the slave samples scan_in on the rising clock edge and
// consumes it. There is no ready signal because the decoder always accepts.
// The status outputs are registered in the slave. value_upd and frame_done
// are single-cycle pulses. The err_* flags stay set until reset.
interface seg_scan_decoder_if;
    logic        scan_en;
    logic [15:0] scan_in;
    logic [15:0] value;
    logic        value_vld;
    logic        value_upd;
    logic        frame_done;
    logic        err_anode;
    logic        err_seg;
    logic        err_order;

    modport master (
        output scan_en, scan_in,
        input  value, value_vld, value_upd, frame_done,
        input  err_anode, err_seg, err_order
    );

    modport slave (
        input  scan_en, scan_in,
        output value, value_vld, value_upd, frame_done,
        output err_anode, err_seg, err_order
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decoder for the scanned 7-segment display word. It decodes each sampled
// {anode, segment} pair back to a hex nibble and assembles four digits into a
// frame. A frame is published once STABLE_FRAMES identical frames arrive in a
// row. STABLE_FRAMES must lie in 1..15.
module seg_scan_decoder #(
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic               pose,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [3:0] SF = 4'(STABLE_FRAMES);

    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  stable_q, stable_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] value_q, value_d;
    logic        vld_q, vld_d;
    logic        upd_q, upd_d;
    logic        fd_q, fd_d;
    logic        ea_q, ea_d;
    logic        es_q, es_d;
    logic        eo_q, eo_d;

    logic [3:0]  anode;
    logic        anode_ok;
    logic        seg_ok;
    logic [3:0]  seg_nib;
    logic [3:0]  mask_mid;

    // The anode field must be exactly one-hot, and the upper nibble must be clear.
    assign anode    = bus.scan_in[11:8];
    assign anode_ok = (bus.scan_in[15:12] == 4'h0) && (anode != 4'h0) &&
                      ((anode & (anode - 4'd1)) == 4'h0);

    // Exact-match segment decode. The pattern for 5 is 8'h67 on this display.
    // Any byte with the dp bit set is rejected.
    always_comb begin
        seg_ok  = 1'b1;
        seg_nib = 4'h0;
        case (bus.scan_in[7:0])
            8'h3F: seg_nib = 4'h0;
            8'h06: seg_nib = 4'h1;
            8'h5B: seg_nib = 4'h2;
            8'h4F: seg_nib = 4'h3;
            8'h66: seg_nib = 4'h4;
            8'h67: seg_nib = 4'h5;
            8'h7D: seg_nib = 4'h6;
            8'h07: seg_nib = 4'h7;
            8'h7F: seg_nib = 4'h8;
            8'h6F: seg_nib = 4'h9;
            8'h77: seg_nib = 4'hA;
            8'h7C: seg_nib = 4'hB;
            8'h39: seg_nib = 4'hC;
            8'h5E: seg_nib = 4'hD;
            8'h7B: seg_nib = 4'hE;
            8'h71: seg_nib = 4'hF;
            default: seg_ok = 1'b0;
        endcase
    end

    // Sample handling, frame assembly, stability counting and publishing.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        stable_d = stable_q;
        prev_d   = prev_q;
        value_d  = value_q;
        vld_d    = vld_q;
        upd_d    = 1'b0;
        fd_d     = 1'b0;
        ea_d     = ea_q;
        es_d     = es_q;
        eo_d     = eo_q;
        mask_mid = mask_q;
        if (bus.scan_en) begin
            if (!anode_ok) begin
                ea_d     = 1'b1;
                mask_d   = 4'h0;
                stable_d = 4'h0;
            end else if (!seg_ok) begin
                es_d     = 1'b1;
                mask_d   = 4'h0;
                stable_d = 4'h0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (anode[i]) shadow_d[4*i +: 4] = seg_nib;
                end
                // A repeated digit means the scan skipped digits. Restart the
                // frame from this digit and keep its new nibble.
                if ((mask_q & anode) != 4'h0) begin
                    eo_d     = 1'b1;
                    mask_mid = anode;
                end else begin
                    mask_mid = mask_q | anode;
                end
                if (mask_mid == 4'hF) begin
                    fd_d   = 1'b1;
                    mask_d = 4'h0;
                    if (shadow_d == prev_q) begin
                        stable_d = (stable_q >= SF) ? SF : 4'(stable_q + 4'd1);
                    end else begin
                        stable_d = 4'd1;
                        prev_d   = shadow_d;
                    end
                    if ((stable_d == SF) && (!vld_q || (shadow_d != value_q))) begin
                        value_d = shadow_d;
                        vld_d   = 1'b1;
                        upd_d   = 1'b1;
                    end
                end else begin
                    mask_d = mask_mid;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge pose) begin
        if (rst) begin
            shadow_q <= 16'h0;
            mask_q   <= 4'h0;
            stable_q <= 4'h0;
            prev_q   <= 16'h0;
            value_q  <= 16'h0;
            vld_q    <= 1'b0;
            upd_q    <= 1'b0;
            fd_q     <= 1'b0;
            ea_q     <= 1'b0;
            es_q     <= 1'b0;
            eo_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            value_q  <= value_d;
            vld_q    <= vld_d;
            upd_q    <= upd_d;
            fd_q     <= fd_d;
            ea_q     <= ea_d;
            es_q     <= es_d;
            eo_q     <= eo_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.value_vld  = vld_q;
    assign bus.value_upd  = upd_q;
    assign bus.frame_done = fd_q;
    assign bus.err_anode  = ea_q;
    assign bus.err_seg    = es_q;
    assign bus.err_order  = eo_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder. A frame-level reference model predicts the
// outputs after every cycle, and each scenario task compares them inline.
module tb_seg_scan_decoder;

    localparam int SF = 2;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h67, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h7B, 8'h71
    };

    // ---------------- clock / reset ----------------
    logic pose = 1'b0;
    logic rst  = 1'b0;
    always #5 pose = ~pose;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.STABLE_FRAMES(SF)) dut (
        .pose (pose),
        .rst  (rst),
        .bus  (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [3:0]  m_dig [4];
    bit          m_have [4];
    logic [15:0] m_prev, m_value;
    int          m_cnt;
    bit          m_vld, m_ea, m_es, m_eo;
    logic [21:0] exp_q [$];
    logic [15:0] sq [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [21:0] obs_vec();
        return {bus.value, bus.value_vld, bus.value_upd, bus.frame_done,
                bus.err_anode, bus.err_seg, bus.err_order};
    endfunction

    function automatic logic [15:0] enc(input int d, input int n);
        logic [3:0] a;
        a = 4'b0001 << d;
        return {4'h0, a, SEG_TAB[n]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_dig[i]  = 4'h0;
            m_have[i] = 1'b0;
        end
        m_prev = 16'h0; m_value = 16'h0; m_cnt = 0;
        m_vld = 0; m_ea = 0; m_es = 0; m_eo = 0;
        exp_q.delete();
    endtask

    task automatic clear_have();
        for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
    endtask

    task automatic model_push(input bit upd, input bit fd);
        exp_q.push_back({m_value, m_vld, upd, fd, m_ea, m_es, m_eo});
    endtask

    task automatic model_sample(input logic [15:0] w);
        int ones = 0;
        int d    = -1;
        int nib  = -1;
        bit upd  = 1'b0;
        logic [15:0] frame;
        for (int i = 0; i < 4; i++) begin
            if (w[8+i]) begin ones++; d = i; end
        end
        if (w[15:12] != 4'h0 || ones != 1) begin
            m_ea = 1; clear_have(); m_cnt = 0; model_push(0, 0); return;
        end
        for (int k = 0; k < 16; k++) if (SEG_TAB[k] == w[7:0]) nib = k;
        if (nib < 0) begin
            m_es = 1; clear_have(); m_cnt = 0; model_push(0, 0); return;
        end
        if (m_have[d]) begin
            m_eo = 1; clear_have();
        end
        m_dig[d]  = nib[3:0];
        m_have[d] = 1'b1;
        if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
            frame = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            clear_have();
            if (frame == m_prev) m_cnt = (m_cnt + 1 > SF) ? SF : m_cnt + 1;
            else begin m_cnt = 1; m_prev = frame; end
            if (m_cnt == SF && (!m_vld || frame != m_value)) begin
                m_value = frame; m_vld = 1; upd = 1;
            end
            model_push(upd, 1);
        end else begin
            model_push(0, 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input logic [15:0] w);
        bus.scan_en = en;
        bus.scan_in = w;
        @(posedge pose);
        #1;
        if (en) model_sample(w);
        else    model_push(0, 0);
        bus.scan_en = 1'b0;
    endtask

    task automatic add_frame(input logic [15:0] v);
        for (int d = 0; d < 4; d++) sq.push_back(enc(d, int'(v[4*d +: 4])));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.scan_en = 1'b1;
        bus.scan_in = enc(0, 1);
        @(posedge pose);
        #1;
        rst = 1'b0;
        bus.scan_en = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (obs_vec() !== 22'h0) begin
            bad++; $display("FAIL reset: got %h want %h", obs_vec(), 22'h0);
        end
    endtask

    task automatic test_publish();
        logic [21:0] ex;
        sq.delete();
        add_frame(16'h1234); add_frame(16'h1234);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL publish[%0d]: got %h want %h", i, obs_vec(), ex);
            end
            if (i == 3) begin
                total++;
                if ({bus.frame_done, bus.value_upd, bus.value_vld} !== 3'b100) begin
                    bad++; $display("FAIL first_frame: got fd/upd/vld=%b want 100",
                                    {bus.frame_done, bus.value_upd, bus.value_vld});
                end
            end
        end
        total++;
        if ({bus.value, bus.value_vld, bus.value_upd} !== {16'h1234, 2'b11}) begin
            bad++; $display("FAIL publish_value: got %h/%b/%b want 1234/1/1",
                            bus.value, bus.value_vld, bus.value_upd);
        end
    endtask

    task automatic test_steady();
        logic [21:0] ex;
        int fd_seen = 0;
        int upd_seen = 0;
        sq.delete();
        repeat (5) add_frame(16'h1234);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            fd_seen += int'(bus.frame_done);
            upd_seen += int'(bus.value_upd);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL steady[%0d]: got %h want %h", i, obs_vec(), ex);
            end
        end
        total++;
        if (fd_seen != 5 || upd_seen != 0) begin
            bad++; $display("FAIL steady_counts: got fd=%0d upd=%0d want fd=5 upd=0",
                            fd_seen, upd_seen);
        end
    endtask

    task automatic test_glitch();
        logic [21:0] ex;
        sq.delete();
        add_frame(16'hBEEF); add_frame(16'h1234);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL glitch[%0d]: got %h want %h", i, obs_vec(), ex);
            end
        end
        total++;
        if (bus.value !== 16'h1234) begin
            bad++; $display("FAIL glitch_value: got %h want 1234", bus.value);
        end
    endtask

    task automatic test_errors();
        logic [21:0] ex;
        sq.delete();
        sq.push_back(enc(0, 8)); sq.push_back(enc(1, 7));
        sq.push_back(16'h0179);
        sq.push_back(enc(2, 6)); sq.push_back(enc(3, 5));
        sq.push_back(16'h0340);
        add_frame(16'h5678); add_frame(16'h5678);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL errors[%0d]: got %h want %h", i, obs_vec(), ex);
            end
            if (i == 5) begin
                total++;
                if ({bus.err_anode, bus.err_seg, bus.value, bus.frame_done} !==
                    {2'b11, 16'h1234, 1'b0}) begin
                    bad++; $display("FAIL err_flags: got ea=%b es=%b value=%h fd=%b want 1 1 1234 0",
                                    bus.err_anode, bus.err_seg, bus.value, bus.frame_done);
                end
            end
        end
        total++;
        if (bus.value !== 16'h5678) begin
            bad++; $display("FAIL errors_recover: got %h want 5678", bus.value);
        end
    endtask

    task automatic test_order();
        logic [21:0] ex;
        sq.delete();
        sq.push_back(enc(0, 1)); sq.push_back(enc(1, 2));
        sq.push_back(enc(0, 9)); sq.push_back(enc(1, 10));
        sq.push_back(enc(2, 11)); sq.push_back(enc(3, 12));
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL order[%0d]: got %h want %h", i, obs_vec(), ex);
            end
            if (i == 2) begin
                total++;
                if (bus.err_order !== 1'b1) begin
                    bad++; $display("FAIL err_order: got %b want 1", bus.err_order);
                end
            end
        end
        total++;
        if (bus.frame_done !== 1'b1) begin
            bad++; $display("FAIL order_frame: got fd=%b want 1", bus.frame_done);
        end
    endtask

    task automatic test_idle_hold();
        logic [21:0] ex;
        step(1'b1, enc(0, 3)); void'(exp_q.pop_front());
        step(1'b1, enc(1, 4)); void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'($urandom));
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL idle[%0d]: got %h want %h", i, obs_vec(), ex);
            end
        end
        step(1'b1, enc(2, 5)); void'(exp_q.pop_front());
        step(1'b1, enc(3, 6));
        ex = exp_q.pop_front(); total++;
        if (obs_vec() !== ex) begin
            bad++; $display("FAIL idle_resume: got %h want %h", obs_vec(), ex);
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] ex;
        step(1'b1, enc(0, 7)); step(1'b1, enc(1, 7));
        do_reset();
        total++;
        if (obs_vec() !== 22'h0) begin
            bad++; $display("FAIL reset_mid: got %h want %h", obs_vec(), 22'h0);
        end
        sq.delete();
        sq.push_back(enc(2, 1)); sq.push_back(enc(3, 2));
        sq.push_back(enc(0, 3)); sq.push_back(enc(1, 4));
        add_frame(16'h2143);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i]);
            ex = exp_q.pop_front(); total++;
            if (obs_vec() !== ex) begin
                bad++; $display("FAIL reset_mid[%0d]: got %h want %h", i, obs_vec(), ex);
            end
            if (i == 1) begin
                total++;
                if (bus.frame_done !== 1'b0) begin
                    bad++; $display("FAIL stale_digits: got fd=%b want 0", bus.frame_done);
                end
            end
        end
        total++;
        if ({bus.value, bus.value_vld} !== {16'h2143, 1'b1}) begin
            bad++; $display("FAIL reset_mid_value: got %h/%b want 2143/1",
                            bus.value, bus.value_vld);
        end
    endtask

    task automatic test_random();
        logic [21:0] ex;
        logic [15:0] v;
        int ord [4];
        int j, t, reps;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            v = ($urandom_range(0, 2) == 0) ? 16'hA5C3 : 16'($urandom);
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                sq.delete();
                for (int i = 0; i < 4; i++) ord[i] = i;
                for (int i = 3; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    t = ord[i]; ord[i] = ord[j]; ord[j] = t;
                end
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 24) == 0) sq.push_back(16'($urandom));
                    sq.push_back(enc(ord[i], int'(v[4*ord[i] +: 4])));
                end
                for (int i = 0; i < sq.size(); i++) begin
                    step(($urandom_range(0, 7) != 0), sq[i]);
                    ex = exp_q.pop_front(); total++;
                    if (obs_vec() !== ex) begin
                        bad++; $display("FAIL random[%0d.%0d]: got %h want %h", f, i, obs_vec(), ex);
                    end
                end
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        bus.scan_en = 1'b0;
        bus.scan_in = 16'h0;
        model_reset();
        test_reset();
        test_publish();
        test_steady();
        test_glitch();
        test_errors();
        test_order();
        test_idle_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
